vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Source end of the vga_if pixel stream consumed by the drawing pipeline.
- Generates hcount/vcount, blanking and sync for an 800x600@60 Hz SVGA frame at 40 MHz, plus frame_start/line_start strobes.
- Includes a run/stop controller so the display starts only at a frame boundary and stops only at one. The pipeline never sees a torn frame.
- Sits between the clock/reset block and the draw pipeline input.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clk)
- H_SYNC, 128, hsync width (clk)
- H_BP, 88, horizontal back porch; H_TOTAL = 1056
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch; V_TOTAL = 628
- SYNC_POL, 1'b1, active level of hsync/vsync

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level request to run the display
- vga_out  vga_if.out  hcount 11 / vcount 11 / hblnk, vblnk, hsync, vsync 1 each  timing stream to draw pipeline
- frame_start  out  1  1-cycle pulse coincident with hcount=0, vcount=0 of each running frame
- line_start  out  1  1-cycle pulse coincident with hcount=0 of each running line
- running  out  1  high in RUN or STOPPING

Behaviour:
- Single clock. Every output is a flop. Reset is asynchronous and active-low on rst.
- Reset values:
  - hcount = 0, vcount = 0
  - hblnk = 1, vblnk = 1
  - hsync = vsync = ~SYNC_POL
  - frame_start = 0, line_start = 0, running = 0
  - state = IDLE
- Counters:
  - hcount increments 0..H_TOTAL-1, then wraps to 0.
  - vcount increments only on the cycle hcount wraps, 0..V_TOTAL-1, then wraps to 0.
  - Arithmetic is 11-bit unsigned. No other value is ever output.
- Decode from the next-count values, registered together, so that all fields in one cycle describe the same pixel (zero skew):
  - hblnk = (hcount >= H_ACTIVE)
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
  - vblnk and vsync use the same rules applied to vcount
- FSM, states IDLE / RUN / STOPPING:
  - IDLE: counters held at 0; hblnk = vblnk = 1; syncs inactive; strobes 0.
    - enable=1 moves to RUN.
    - The first RUN cycle outputs hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=1, line_start=1.
    - IDLE->RUN latency: 1 clk from enable sampled high.
  - RUN: free-running counters.
    - enable=0 moves to STOPPING; counting continues unchanged.
  - STOPPING: counters continue.
    - enable=1 returns to RUN with no glitch in counts.
    - If the current pixel is (H_TOTAL-1, V_TOTAL-1) and enable=0, the next state is IDLE. IDLE outputs appear the following cycle.
    - The frame in progress is always completed.
- Simultaneous events:
  - enable deasserted on the last pixel of a frame while in RUN: goes to STOPPING, then completes one further full frame before IDLE. The stop decision uses the state register only.
  - enable toggling every cycle in RUN: no effect on counts.
- Strobes:
  - frame_start is high only when the output shows (0,0) and the state is RUN or STOPPING.
  - line_start is high when hcount=0 under the same condition.
- Reset asserted mid-frame forces reset values immediately (async). After release, the block starts in IDLE.

Decomposition:
- vga_pkg holds the timing constants (H_*/V_* values, H_TOTAL, V_TOTAL) and the 11-bit count width.
- snake_pkg holds a typedef enum for the tg_state (IDLE, RUN, STOPPING).
- One natural sub-module: vga_mod_counter (parameter MOD, ports clk, rst, en, cnt, wrap, clr), instantiated twice:
  - horizontal: en tied high when running
  - vertical: en = horizontal wrap

Test Plan:
- Reset held low with enable=1: hcount=0, vcount=0, hblnk=vblnk=1, hsync=vsync=0. Release → one cycle later frame_start=1 at (0,0) with blanks=0.
- Run one line: hblnk rises at hcount=800. hsync high for hcount 840..967 (128 cycles). hcount wraps 1055→0 and vcount 0→1 in the same cycle.
- Run one full frame: vblnk rises at vcount=600. vsync high for vcount 601..604. frame_start pulses exactly every 1056*628 = 663168 clk.
- Drop enable at vcount=300: outputs continue to (1055,627), then IDLE (blanks=1, counts 0). running falls in the same cycle.
- Drop enable at vcount=300, re-raise at vcount=500: no IDLE entry. Counts contiguous. Next frame_start at the normal period.
- Assert rst at hcount=400, vcount=200: all outputs take reset values within the same cycle (asynchronous). No frame_start until re-entry from IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snake_pkg : run/stop controller state encoding for the timing generator     |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
package snake_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } tg_state_t;
endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : 800x600@60 Hz SVGA timing constants and count width               |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
package vga_pkg;
    localparam int CNT_W    = 11;
    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_if : pixel timing stream from the generator to the draw pipeline        |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface vga_if;
    import vga_pkg::*;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;

    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface
`default_nettype wire

// File: rtl/vga_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_mod_counter : modulo-MOD up counter with clear and qualified wrap flag  |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_mod_counter #(
    parameter int MOD = 1056,
    parameter int W   = 11
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          en,
    input  wire          clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // wrap is qualified by en so it can directly enable a cascaded counter
    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen : SVGA counters, blank/sync decode and frame-aligned run/stop |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::CNT_W;
    import snake_pkg::*;
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = 1'b1
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  enable,
    vga_if.out   vga_out,
    output logic frame_start,
    output logic line_start,
    output logic running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HB_BEG = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VB_BEG = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    tg_state_t        state;
    tg_state_t        state_nxt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_en;
    logic             h_wrap;
    logic             v_wrap;
    logic             clr;
    logic             hblnk_r;
    logic             vblnk_r;
    logic             hsync_r;
    logic             vsync_r;

    assign h_en = (state != IDLE);
    assign clr  = (state_nxt == IDLE);

    vga_mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_en),
        .clr  (clr),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    vga_mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .clr  (clr),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // v_wrap is only ever true on the last pixel of a frame while counting
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (enable) state_nxt = RUN;
            RUN:      if (!enable) state_nxt = STOPPING;
            STOPPING: begin
                if (enable)      state_nxt = RUN;
                else if (v_wrap) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Count values the counters will hold after this edge, so decode lines up with them
    always_comb begin
        h_next = h_cnt;
        v_next = v_cnt;
        if (clr) begin
            h_next = '0;
            v_next = '0;
        end else if (h_en) begin
            h_next = h_wrap ? '0 : h_cnt + CNT_W'(1);
            if (h_wrap) v_next = v_wrap ? '0 : v_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            running     <= 1'b0;
            hblnk_r     <= 1'b1;
            vblnk_r     <= 1'b1;
            hsync_r     <= ~SYNC_POL;
            vsync_r     <= ~SYNC_POL;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            state   <= state_nxt;
            running <= (state_nxt != IDLE);
            if (state_nxt == IDLE) begin
                hblnk_r     <= 1'b1;
                vblnk_r     <= 1'b1;
                hsync_r     <= ~SYNC_POL;
                vsync_r     <= ~SYNC_POL;
                frame_start <= 1'b0;
                line_start  <= 1'b0;
            end else begin
                hblnk_r     <= (h_next >= HB_BEG);
                vblnk_r     <= (v_next >= VB_BEG);
                hsync_r     <= ((h_next >= HS_BEG) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
                vsync_r     <= ((v_next >= VS_BEG) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
                frame_start <= (h_next == '0) && (v_next == '0);
                line_start  <= (h_next == '0);
            end
        end
    end

    assign vga_out.hcount = h_cnt;
    assign vga_out.vcount = v_cnt;
    assign vga_out.hblnk  = hblnk_r;
    assign vga_out.vblnk  = vblnk_r;
    assign vga_out.hsync  = hsync_r;
    assign vga_out.vsync  = vsync_r;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen : directed checks on a full-size and a reduced-size DUT    |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;
    // Reduced geometry for frame-level scenarios: 24 x 18 = 432 clocks per frame
    localparam int SH_ACT = 16, SH_FP = 2, SH_SYNC = 4, SH_BP = 2, SH_TOT = 24;
    localparam int SV_ACT = 10, SV_FP = 1, SV_SYNC = 4, SV_BP = 3, SV_TOT = 18;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic fs_a, ls_a, run_a;
    logic fs_b, ls_b, run_b;
    int   n_checks = 0;
    int   n_errors = 0;

    vga_if vga_a ();
    vga_if vga_b ();

    vga_timing_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .enable      (en_a),
        .vga_out     (vga_a),
        .frame_start (fs_a),
        .line_start  (ls_a),
        .running     (run_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_ACT), .H_FP (SH_FP), .H_SYNC (SH_SYNC), .H_BP (SH_BP),
        .V_ACTIVE (SV_ACT), .V_FP (SV_FP), .V_SYNC (SV_SYNC), .V_BP (SV_BP),
        .SYNC_POL (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable      (en_b),
        .vga_out     (vga_b),
        .frame_start (fs_b),
        .line_start  (ls_b),
        .running     (run_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hs_cnt, vs_cnt, fs_cnt, gap, bad, idx;

        // ---- reset held with enable high on the full-size DUT
        en_a = 1'b1;
        tick(3);
        check("a_rst_hcount", vga_a.hcount, 0);
        check("a_rst_vcount", vga_a.vcount, 0);
        check("a_rst_hblnk",  vga_a.hblnk,  1);
        check("a_rst_vblnk",  vga_a.vblnk,  1);
        check("a_rst_hsync",  vga_a.hsync,  0);
        check("a_rst_vsync",  vga_a.vsync,  0);
        check("a_rst_fs",     fs_a,         0);
        check("a_rst_ls",     ls_a,         0);
        check("a_rst_run",    run_a,        0);
        check("b_rst_hsync",  vga_b.hsync,  1);
        check("b_rst_vsync",  vga_b.vsync,  1);

        rst = 1'b1;
        tick(1);
        check("a_first_fs",    fs_a,         1);
        check("a_first_ls",    ls_a,         1);
        check("a_first_hblnk", vga_a.hblnk,  0);
        check("a_first_vblnk", vga_a.vblnk,  0);
        check("a_first_run",   run_a,        1);
        check("a_first_h",     vga_a.hcount, 0);

        // ---- one full line on the full-size DUT
        hs_cnt = 0;
        for (int k = 1; k <= 1056; k++) begin
            tick(1);
            if (vga_a.hsync) hs_cnt++;
            if (k == 1)    check("a_fs_drop",  fs_a, 0);
            if (k == 799)  check("a_hblnk_799", vga_a.hblnk, 0);
            if (k == 800)  check("a_hblnk_800", vga_a.hblnk, 1);
            if (k == 839)  check("a_hsync_839", vga_a.hsync, 0);
            if (k == 840)  check("a_hsync_840", vga_a.hsync, 1);
            if (k == 967)  check("a_hsync_967", vga_a.hsync, 1);
            if (k == 968)  check("a_hsync_968", vga_a.hsync, 0);
            if (k == 1055) begin
                check("a_h_1055",   vga_a.hcount, 1055);
                check("a_v_line0",  vga_a.vcount, 0);
            end
            if (k == 1056) begin
                check("a_h_wrap",   vga_a.hcount, 0);
                check("a_v_line1",  vga_a.vcount, 1);
                check("a_ls_line1", ls_a,         1);
                check("a_fs_line1", fs_a,         0);
                check("a_hblnk_l1", vga_a.hblnk,  0);
            end
        end
        check("a_hsync_width", hs_cnt, 128);

        // ---- asynchronous reset mid-line
        tick(400);
        check("a_h_400", vga_a.hcount, 400);
        #3;
        rst = 1'b0;
        #1;
        check("a_async_h",     vga_a.hcount, 0);
        check("a_async_v",     vga_a.vcount, 0);
        check("a_async_hblnk", vga_a.hblnk,  1);
        check("a_async_run",   run_a,        0);
        en_a = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        check("a_post_rst_run", run_a, 0);
        check("a_post_rst_fs",  fs_a,  0);
        en_a = 1'b1;
        tick(1);
        check("a_reentry_fs", fs_a, 1);
        en_a = 1'b0;

        // ---- full frame on the reduced DUT (active-low syncs)
        en_b = 1'b1;
        tick(1);
        check("b_first_fs",    fs_b,        1);
        check("b_first_hsync", vga_b.hsync, 1);
        vs_cnt = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 432; k++) begin
            tick(1);
            if (!vga_b.vsync) vs_cnt++;
            if (fs_b) fs_cnt++;
            if (k == 15)  check("b_hblnk_15",  vga_b.hblnk, 0);
            if (k == 16)  check("b_hblnk_16",  vga_b.hblnk, 1);
            if (k == 17)  check("b_hsync_17",  vga_b.hsync, 1);
            if (k == 18)  check("b_hsync_18",  vga_b.hsync, 0);
            if (k == 21)  check("b_hsync_21",  vga_b.hsync, 0);
            if (k == 22)  check("b_hsync_22",  vga_b.hsync, 1);
            if (k == 239) check("b_vblnk_v9",  vga_b.vblnk, 0);
            if (k == 240) check("b_vblnk_v10", vga_b.vblnk, 1);
            if (k == 263) check("b_vsync_v10", vga_b.vsync, 1);
            if (k == 264) check("b_vsync_v11", vga_b.vsync, 0);
            if (k == 359) check("b_vsync_v14", vga_b.vsync, 0);
            if (k == 360) check("b_vsync_v15", vga_b.vsync, 1);
            if (k == 432) begin
                check("b_frame_fs", fs_b,         1);
                check("b_frame_h",  vga_b.hcount, 0);
                check("b_frame_v",  vga_b.vcount, 0);
            end
        end
        check("b_vsync_width", vs_cnt, 96);
        check("b_fs_per_frame", fs_cnt, 1);

        // ---- drop enable mid-frame: finish the frame, then idle
        tick(120);
        check("b_stop_v5", vga_b.vcount, 5);
        en_b = 1'b0;
        gap = 0;
        fs_cnt = 0;
        for (int j = 1; j <= 311; j++) begin
            tick(1);
            if (!run_b) gap++;
            if (fs_b) fs_cnt++;
        end
        check("b_stop_last_h", vga_b.hcount, 23);
        check("b_stop_last_v", vga_b.vcount, 17);
        check("b_stop_gap",    gap,          0);
        check("b_stop_no_fs",  fs_cnt,       0);
        tick(1);
        check("b_idle_h",     vga_b.hcount, 0);
        check("b_idle_v",     vga_b.vcount, 0);
        check("b_idle_hblnk", vga_b.hblnk,  1);
        check("b_idle_vblnk", vga_b.vblnk,  1);
        check("b_idle_vsync", vga_b.vsync,  1);
        check("b_idle_run",   run_b,        0);
        check("b_idle_fs",    fs_b,         0);
        tick(3);
        check("b_idle_hold_h",   vga_b.hcount, 0);
        check("b_idle_hold_run", run_b,        0);

        // ---- drop at v5, re-raise at v8: no idle, contiguous counts
        en_b = 1'b1;
        tick(1);
        check("b_restart_fs", fs_b, 1);
        tick(120);
        en_b = 1'b0;
        gap = 0;
        bad = 0;
        fs_cnt = 0;
        for (int j = 1; j <= 312; j++) begin
            tick(1);
            idx = 120 + j;
            if (vga_b.hcount != 11'(idx % SH_TOT)) bad++;
            if (vga_b.vcount != 11'((idx / SH_TOT) % SV_TOT)) bad++;
            if (!run_b) gap++;
            if (fs_b) fs_cnt++;
            if (j == 72) en_b = 1'b1;
        end
        check("b_resume_contig", bad,    0);
        check("b_resume_gap",    gap,    0);
        check("b_resume_fs_cnt", fs_cnt, 1);
        check("b_resume_fs",     fs_b,   1);

        // ---- drop enable on the last pixel while running: one more full frame
        tick(431);
        check("b_last_h", vga_b.hcount, 23);
        check("b_last_v", vga_b.vcount, 17);
        en_b = 1'b0;
        tick(1);
        check("b_extra_fs",  fs_b,  1);
        check("b_extra_run", run_b, 1);
        tick(431);
        check("b_extra_end_run", run_b,        1);
        check("b_extra_end_v",   vga_b.vcount, 17);
        tick(1);
        check("b_extra_idle_run",   run_b,       0);
        check("b_extra_idle_vblnk", vga_b.vblnk, 1);

        // ---- enable toggling every cycle while running
        en_b = 1'b1;
        tick(1);
        check("b_toggle_fs", fs_b, 1);
        bad = 0;
        gap = 0;
        for (int j = 1; j <= 100; j++) begin
            en_b = ~en_b;
            tick(1);
            if (vga_b.hcount != 11'(j % SH_TOT)) bad++;
            if (vga_b.vcount != 11'(j / SH_TOT)) bad++;
            if (!run_b) gap++;
        end
        check("b_toggle_contig", bad, 0);
        check("b_toggle_gap",    gap, 0);
        check("b_toggle_h",      vga_b.hcount, 4);
        check("b_toggle_v",      vga_b.vcount, 4);

        // ---- asynchronous reset mid-frame on the reduced DUT
        #3;
        rst = 1'b0;
        #1;
        check("b_async_h",     vga_b.hcount, 0);
        check("b_async_v",     vga_b.vcount, 0);
        check("b_async_hblnk", vga_b.hblnk,  1);
        check("b_async_hsync", vga_b.hsync,  1);
        check("b_async_run",   run_b,        0);
        check("b_async_ls",    ls_b,         0);
        en_b = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        check("b_post_rst_run", run_b, 0);
        check("b_post_rst_fs",  fs_b,  0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
